mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory access controller between the CPU datapath bus and the synchronous word RAM. Holds the Memory Address Register (MAR) and Memory Data Register (MDR), sequences single-word reads and writes against the RAM's one-cycle registered read port, and reports completion to the control unit with a `done` pulse. Every `ld`/`st`/`ldi` memory phase in the control sequence passes through this block.

## Interface
- `DATA_W`, default 32: word width of the bus, MDR and RAM data.
- `ADDR_W`, default 9: RAM address width, covering 512 words.

- `clk` in 1: single clock; everything updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `bus_in` in DATA_W: datapath bus value.
- `mar_in` in 1: load MAR from `bus_in[ADDR_W-1:0]`; upper bits are ignored.
- `mdr_in` in 1: load MDR from `bus_in`.
- `rd_req` in 1: start a read from RAM[MAR] into MDR.
- `wr_req` in 1: start a write of MDR to RAM[MAR].
- `mdr_out` out DATA_W: current MDR contents, driven to the bus.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `ram_addr` out ADDR_W: equals MAR at all times.
- `ram_wdata` out DATA_W: equals MDR at all times.
- `ram_we` out 1: RAM write enable.
- `ram_re` out 1: RAM read enable.
- `ram_rdata` in DATA_W: RAM registered read data, valid the cycle after `ram_re`.

## Operation
- The FSM states are IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE and DONE.
- **IDLE**
  - `mar_in` and `mdr_in` load on the clock edge.
  - If `wr_req` is high, go to WR_ISSUE. Otherwise, if `rd_req` is high, go to RD_ISSUE.
  - When both requests are high, the write wins and the read is dropped. The control unit must reassert the read.
- **Load and request in the same IDLE cycle:** the access uses the newly loaded MAR/MDR. Issue happens in the next state, so no bypass is needed.
- **RD_ISSUE:** `ram_re`=1. Always go to RD_WAIT.
- **RD_WAIT:** `ram_re`=0. MDR <= `ram_rdata` at the end of the cycle. Go to DONE.
- **WR_ISSUE:** `ram_we`=1. Go to DONE.
- **DONE:** `done`=1. Return to IDLE.
- **Outside IDLE:**
  - `mar_in`, `mdr_in`, `rd_req` and `wr_req` are ignored. MAR and MDR are frozen, except for the RD_WAIT capture.
  - Requests are not queued.
- `ram_we` and `ram_re` are decoded from the state only. They are never high together, and each is high for exactly one cycle per access.

## Timing
- **Reset values:** state IDLE; MAR=0; MDR=0; `mdr_out`=0, `ram_addr`=0, `ram_wdata`=0; `busy`=0, `done`=0, `ram_we`=0, `ram_re`=0.
- **Read:** request sampled at edge 0. Cycle 1 is RD_ISSUE, cycle 2 is RD_WAIT, cycle 3 is DONE. The new `mdr_out` is valid in cycle 3, together with `done`. Total latency is 3 cycles.
- **Write:** request sampled at edge 0. Cycle 1 is WR_ISSUE and the RAM captures at the end of cycle 1. Cycle 2 is DONE. Total latency is 2 cycles.
- **Back-to-back:** the earliest next request is sampled in the first IDLE cycle after DONE. Minimum spacing is 4 cycles for reads and 3 cycles for writes.
- **Reset mid-operation:** on the next edge all registers return to their reset values and `done` is not produced. An in-flight RAM read result is discarded. A write already issued in WR_ISSUE is allowed to have completed in the RAM.

## Structure
- Shared package `mem_ctrl_pkg` holds the state enumeration and the `DATA_W`/`ADDR_W` default constants. The same constants are used to size the RAM.
- One sub-module is natural: `reg_en`, an enable-loaded register with synchronous active-high reset. It is instantiated for MAR (ADDR_W) and MDR (DATA_W). The MDR load select chooses `bus_in` in IDLE and `ram_rdata` in RD_WAIT.
- The FSM and output decode stay in the top module.

## Test plan
- **Reset:** assert `reset` for 2 cycles with requests high. Required response: all outputs 0, `busy`=0, no `ram_we` or `ram_re`.
- **Read:** RAM model preloaded with [0x054]=0x00000097. Drive `bus_in`=0x54 with `mar_in` and `rd_req` in the same cycle. Required response:
  - `ram_re` high only in cycle 1, with `ram_addr`=0x054.
  - `done` high only in cycle 3, with `mdr_out`=0x00000097.
- **Write then read-back:** load MAR=0x068, then MDR=0x000000BC, then `wr_req`. Required response:
  - `ram_we` high in cycle 1 with address 0x068 and data 0xBC, `done` in cycle 2.
  - Clear MDR via `bus_in`=0 and `mdr_in`, then read 0x068. `mdr_out` must read 0x000000BC.
- **Simultaneous requests:** `rd_req` and `wr_req` high together in IDLE. Required response: exactly one `ram_we` pulse, no `ram_re`, `done` after 2 cycles.
- **Inputs while busy:** assert `rd_req`, `wr_req`, `mar_in` with `bus_in`=0x1FF, and `mdr_in` during RD_ISSUE and RD_WAIT. Required response: MAR unchanged, only one access performed, only one `done` pulse.
- **Reset during RD_WAIT:** pulse `reset` while in RD_WAIT with the RAM returning 0xDEADBEEF. Required response: `mdr_out`=0, no `done`, IDLE in the following cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths and FSM state encoding for the memory access controller
package mem_ctrl_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE} state_e;
endpackage

// File: rtl/reg_en.sv
// reg_en: enable-loaded register with synchronous active-high reset
module reg_en #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q, q_d;
   always_comb q_d = en ? d : q_q;
   always_ff @(posedge clk) q_q <= reset ? '0 : q_d;
   assign q = q_q;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: MAR/MDR holder sequencing single-word reads and writes against a registered-read RAM
module mem_ctrl #(
   parameter int DATA_W = mem_ctrl_pkg::DATA_W,
   parameter int ADDR_W = mem_ctrl_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              mar_in,
   input  logic              mdr_in,
   input  logic              rd_req,
   input  logic              wr_req,
   output logic [DATA_W-1:0] mdr_out,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata
);
   import mem_ctrl_pkg::*;
   state_e state_q, state_d;
   logic idle, rd_wait, mar_en, mdr_en;
   logic [DATA_W-1:0] mdr_d;
   assign idle    = state_q == IDLE;
   assign rd_wait = state_q == RD_WAIT;
   // write wins over a simultaneous read; the dropped read must be reasserted
   always_comb begin
      state_d = idle                  ? (wr_req ? WR_ISSUE : rd_req ? RD_ISSUE : IDLE) :
                state_q == RD_ISSUE   ? RD_WAIT :
                rd_wait               ? DONE :
                state_q == WR_ISSUE   ? DONE : IDLE;
      mar_en  = idle & mar_in;
      mdr_en  = (idle & mdr_in) | rd_wait;
      mdr_d   = rd_wait ? ram_rdata : bus_in;
   end
   always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
   reg_en #(.W(ADDR_W)) u_mar (
      .clk(clk), .reset(reset), .en(mar_en), .d(bus_in[ADDR_W-1:0]), .q(ram_addr)
   );
   reg_en #(.W(DATA_W)) u_mdr (
      .clk(clk), .reset(reset), .en(mdr_en), .d(mdr_d), .q(mdr_out)
   );
   assign ram_wdata = mdr_out;
   assign busy      = !idle;
   assign done      = state_q == DONE;
   assign ram_re    = state_q == RD_ISSUE;
   assign ram_we    = state_q == WR_ISSUE;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed plus randomized checks of mem_ctrl against a transaction-level memory model
module tb_mem_ctrl;
   logic        clk = 0;
   logic        reset;
   logic [31:0] bus_in;
   logic        mar_in, mdr_in, rd_req, wr_req;
   logic [31:0] mdr_out, ram_wdata, ram_rdata;
   logic        busy, done, ram_we, ram_re;
   logic [8:0]  ram_addr;
   logic [31:0] ram [512];
   logic [31:0] ref_mem [512];
   logic [8:0]  ref_mar;
   logic [31:0] ref_mdr;
   int checks = 0, fails = 0;

   mem_ctrl dut (
      .clk(clk), .reset(reset), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
      .rd_req(rd_req), .wr_req(wr_req), .mdr_out(mdr_out), .busy(busy), .done(done),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram[ram_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_in();
      mar_in = 0; mdr_in = 0; rd_req = 0; wr_req = 0; bus_in = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " done"}, done, 0);
      chk({tag, " we/re"}, {ram_we, ram_re}, 0);
   endtask

   // load MAR and request a read in one IDLE cycle; read takes 3 cycles to done
   task automatic do_read(input logic [8:0] a);
      bus_in = 32'(a); mar_in = 1; rd_req = 1;
      tick();
      clear_in();
      chk("rd c1 re", {ram_we, ram_re}, 2'b01);
      chk("rd c1 addr", ram_addr, a);
      chk("rd c1 busy/done", {busy, done}, 2'b10);
      chk("rd c1 mdr frozen", mdr_out, ref_mdr);
      tick();
      chk("rd c2 we/re", {ram_we, ram_re}, 0);
      chk("rd c2 busy/done", {busy, done}, 2'b10);
      chk("rd c2 mdr frozen", mdr_out, ref_mdr);
      tick();
      ref_mar = a; ref_mdr = ref_mem[a];
      chk("rd c3 busy/done", {busy, done}, 2'b11);
      chk("rd c3 mdr", mdr_out, ref_mdr);
      tick();
      chk_idle("rd c4");
   endtask

   // write takes 2 cycles to done; MAR and MDR assumed already loaded
   task automatic do_write_req(input logic both);
      wr_req = 1; rd_req = both;
      tick();
      clear_in();
      chk("wr c1 we", {ram_we, ram_re}, 2'b10);
      chk("wr c1 addr", ram_addr, ref_mar);
      chk("wr c1 data", ram_wdata, ref_mdr);
      tick();
      ref_mem[ref_mar] = ref_mdr;
      chk("wr c2 we/re", {ram_we, ram_re}, 0);
      chk("wr c2 done", {busy, done}, 2'b11);
      tick();
      chk_idle("wr c3");
   endtask

   task automatic load_mar(input logic [8:0] a);
      bus_in = {$urandom} & 32'hFFFF_FE00 | 32'(a); mar_in = 1;
      tick();
      clear_in();
      ref_mar = a;
      chk("mar load", ram_addr, a);
   endtask

   task automatic load_mdr(input logic [31:0] d);
      bus_in = d; mdr_in = 1;
      tick();
      clear_in();
      ref_mdr = d;
      chk("mdr load", mdr_out, d);
   endtask

   initial begin
      int seen_we, seen_re, seen_done;
      logic [31:0] v;
      logic [8:0]  a;
      for (int i = 0; i < 512; i++) begin
         ram[i] = $urandom;
         ref_mem[i] = ram[i];
      end
      ram[9'h054] = 32'h97; ref_mem[9'h054] = 32'h97;
      ref_mar = 0; ref_mdr = 0;
      clear_in();
      reset = 1; rd_req = 1; wr_req = 1; mar_in = 1; mdr_in = 1; bus_in = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_idle("reset");
         chk("reset mdr", mdr_out, 0);
         chk("reset addr", ram_addr, 0);
         chk("reset wdata", ram_wdata, 0);
      end
      reset = 0;
      clear_in();
      tick();
      chk_idle("post reset");

      do_read(9'h054);

      load_mar(9'h068);
      load_mdr(32'hBC);
      do_write_req(0);
      load_mdr(32'h0);
      do_read(9'h068);
      chk("readback", mdr_out, 32'hBC);

      load_mar(9'h123);
      load_mdr(32'hCAFE_F00D);
      do_write_req(1);
      chk("simul ram", ram[9'h123], 32'hCAFE_F00D);

      // every control input asserted during RD_ISSUE and RD_WAIT must be ignored
      bus_in = 32'h054; mar_in = 1; rd_req = 1;
      tick();
      seen_we = 0; seen_re = 0; seen_done = 0;
      bus_in = 32'h1FF; mar_in = 1; mdr_in = 1; rd_req = 1; wr_req = 1;
      for (int c = 1; c <= 6; c++) begin
         if (c == 3) clear_in();
         seen_we += int'(ram_we); seen_re += int'(ram_re); seen_done += int'(done);
         if (c <= 3) chk("busy mar", ram_addr, 9'h054);
         if (c == 3) chk("busy mdr", mdr_out, 32'h97);
         tick();
      end
      ref_mar = 9'h054; ref_mdr = 32'h97;
      chk("busy re count", seen_re, 1);
      chk("busy we count", seen_we, 0);
      chk("busy done count", seen_done, 1);
      chk_idle("busy after");

      for (int n = 0; n < 60; n++) begin
         a = 9'($urandom);
         v = $urandom;
         case ($urandom_range(0, 2))
            0: do_read(a);
            1: begin load_mar(a); load_mdr(v); do_write_req(1'($urandom)); end
            default: begin
               bus_in = v; mar_in = 1; mdr_in = 1; wr_req = 1;
               ref_mar = v[8:0]; ref_mdr = v;
               tick();
               clear_in();
               chk("comb we", {ram_we, ram_re}, 2'b10);
               chk("comb addr", ram_addr, v[8:0]);
               chk("comb data", ram_wdata, v);
               tick();
               ref_mem[ref_mar] = ref_mdr;
               chk("comb done", {busy, done}, 2'b11);
               tick();
               chk_idle("comb c3");
            end
         endcase
      end
      for (int i = 0; i < 8; i++) do_read(9'($urandom));

      ram[9'h0AA] = 32'hDEAD_BEEF; ref_mem[9'h0AA] = 32'hDEAD_BEEF;
      bus_in = 32'h0AA; mar_in = 1; rd_req = 1;
      tick();
      clear_in();
      chk("rst c1 re", ram_re, 1);
      tick();
      chk("rst c2 rdata", ram_rdata, 32'hDEAD_BEEF);
      reset = 1;
      tick();
      reset = 0;
      ref_mar = 0; ref_mdr = 0;
      chk("rst mdr", mdr_out, 0);
      chk("rst addr", ram_addr, 0);
      chk_idle("rst");
      tick();
      chk_idle("rst next");
      chk("rst mdr next", mdr_out, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
